apb_uart_fifo_bridge: RTL

//  APB3 slave that bridges the processor bus to the UART TX/RX byte engines through parametrised TX and RX FIFOs.

---
 rtl/apb_uart_fifo_bridge_pkg.sv | 34 +++
 rtl/apb_uart_fifo_bridge_sync_fifo.sv | 69 ++++++
 rtl/apb_uart_fifo_bridge.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_fifo_bridge_pkg.sv
// Shared definitions for the APB UART FIFO bridge: register offsets, bit indices, TX FSM states.
package apb_uart_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_IRQEN  = 2'd3;

    localparam int ST_TXFULL    = 0;
    localparam int ST_TXEMPTY   = 1;
    localparam int ST_RXFULL    = 2;
    localparam int ST_RXEMPTY   = 3;
    localparam int ST_TXBUSY    = 4;
    localparam int ST_RXOVR     = 5;
    localparam int ST_FERR      = 6;
    localparam int ST_TXCNT_LSB = 8;
    localparam int ST_RXCNT_LSB = 16;

    localparam int CTRL_TXEN    = 0;
    localparam int CTRL_RXEN    = 1;
    localparam int CTRL_TXFLUSH = 2;
    localparam int CTRL_RXFLUSH = 3;

    localparam int IRQ_RXNE = 0;
    localparam int IRQ_TXE  = 1;
    localparam int IRQ_ERR  = 2;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/apb_uart_fifo_bridge_sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop at any fill level and a flush that overrides both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        rdata = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/apb_uart_fifo_bridge.sv
// APB3 zero-wait slave bridging to UART TX/RX byte engines through TX and RX FIFOs.
// Optional IRQEN register and irq output are built when APB_UART_IRQ_EN is defined.
module apb_uart_fifo_bridge
    import apb_uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_err,
    output logic              tx_en,
    output logic              rx_en
`ifdef APB_UART_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic           access;
    logic [1:0]     off;
    logic           tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic           rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0]     tx_rdata, rx_rdata;
    logic [TCW-1:0] tx_count;
    logic [RCW-1:0] rx_count;
    logic [31:0]    status;
    logic           w1c_ovr, w1c_ferr;
    logic           txen_q, txen_d, rxen_q, rxen_d;
    logic           rxovr_q, rxovr_d, ferr_q, ferr_d;
    tx_state_e      state_q;
    logic           tx_start_q;
    logic [7:0]     tx_data_q;
    logic           unused_bits;
`ifdef APB_UART_IRQ_EN
    logic [2:0]     irqen_q, irqen_d;
    logic           irq_q, irq_d;
`endif

    assign unused_bits = ^{paddr[1:0], pwdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .wdata(pwdata[7:0]), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .wdata(rx_data), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        access  = psel & penable;
        off     = paddr[3:2];
        pready  = access;
        status  = '0;
        status[ST_TXFULL]  = tx_full;
        status[ST_TXEMPTY] = tx_empty;
        status[ST_RXFULL]  = rx_full;
        status[ST_RXEMPTY] = rx_empty;
        status[ST_TXBUSY]  = (state_q != T_IDLE);
        status[ST_RXOVR]   = rxovr_q;
        status[ST_FERR]    = ferr_q;
        status[ST_TXCNT_LSB +: 8] = 8'(tx_count);
        status[ST_RXCNT_LSB +: 8] = 8'(rx_count);
        prdata   = '0;
        pslverr  = 1'b0;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        tx_flush = 1'b0;
        rx_flush = 1'b0;
        w1c_ovr  = 1'b0;
        w1c_ferr = 1'b0;
        txen_d   = txen_q;
        rxen_d   = rxen_q;
`ifdef APB_UART_IRQ_EN
        irqen_d  = irqen_q;
`endif
        // Error responses leave every piece of state untouched.
        if (access) begin
            case (off)
                OFF_DATA: begin
                    if (pwrite) begin
                        if (tx_full) pslverr = 1'b1;
                        else         tx_push = 1'b1;
                    end else begin
                        if (rx_empty) begin
                            pslverr = 1'b1;
                        end else begin
                            rx_pop = 1'b1;
                            prdata = {24'h0, rx_rdata};
                        end
                    end
                end
                OFF_STATUS: begin
                    if (pwrite) begin
                        w1c_ovr  = pwdata[ST_RXOVR];
                        w1c_ferr = pwdata[ST_FERR];
                    end else begin
                        prdata = status;
                    end
                end
                OFF_CTRL: begin
                    if (pwrite) begin
                        txen_d   = pwdata[CTRL_TXEN];
                        rxen_d   = pwdata[CTRL_RXEN];
                        tx_flush = pwdata[CTRL_TXFLUSH];
                        rx_flush = pwdata[CTRL_RXFLUSH];
                    end else begin
                        prdata = {30'h0, rxen_q, txen_q};
                    end
                end
                default: begin
`ifdef APB_UART_IRQ_EN
                    if (pwrite) irqen_d = pwdata[2:0];
                    else        prdata  = {29'h0, irqen_q};
`else
                    pslverr = 1'b1;
`endif
                end
            endcase
        end
        tx_pop  = (state_q == T_LOAD) & ~tx_empty;
        rx_push = rx_done & rxen_q;
        rxovr_d = (rxovr_q & ~w1c_ovr) | (rx_push & rx_full & ~rx_pop & ~rx_flush);
        ferr_d  = (ferr_q & ~w1c_ferr) | rx_err;
`ifdef APB_UART_IRQ_EN
        irq_d   = |(irqen_q & {rxovr_q | ferr_q, tx_empty, ~rx_empty});
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txen_q  <= 1'b0;
            rxen_q  <= 1'b0;
            rxovr_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef APB_UART_IRQ_EN
            irqen_q <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            txen_q  <= txen_d;
            rxen_q  <= rxen_d;
            rxovr_q <= rxovr_d;
            ferr_q  <= ferr_d;
`ifdef APB_UART_IRQ_EN
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
`endif
        end
    end

    // T_LOAD re-checks emptiness because a flush may have landed after the IDLE decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= T_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                T_IDLE: if (txen_q && !tx_empty) state_q <= T_LOAD;
                T_LOAD: begin
                    if (!tx_empty) begin
                        tx_data_q  <= tx_rdata;
                        tx_start_q <= 1'b1;
                        state_q    <= T_WAIT;
                    end else begin
                        state_q    <= T_IDLE;
                    end
                end
                T_WAIT: if (tx_done) state_q <= T_IDLE;
                default: state_q <= T_IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = txen_q;
    assign rx_en    = rxen_q;
`ifdef APB_UART_IRQ_EN
    assign irq      = irq_q;
`endif

endmodule
